frightened_timer: RTL and testbench

- Parametrised power-pellet ("frightened mode") controller for the Pac-Man game logic.
- Starts or restarts a frightened window when a pellet is eaten, and flashes a white indicator over the last part of the window.
- Tracks which of NUM_GHOSTS ghosts are still blue, and produces the escalating ghost-eat score (200/400/800/1600).
- Sits between the collision detector and the ghost sprite/colour logic and score accumulator; supports a pause freeze.

---
 rtl/frightened_pkg.sv | 16 +
 rtl/frightened_flash.sv | 51 +++++
 rtl/frightened_timer.sv | 140 ++++++++++++++
 tb/tb_frightened_timer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frightened_pkg.sv
// Shared types and constants for the frightened-mode (power pellet) controller.
package frightened_pkg;

    typedef enum logic [1:0] {IDLE, RUNNING, FLASHING} fright_state_t;

    localparam int unsigned SCORE_BASE = 200;
    localparam int unsigned COMBO_MAX  = 3;
    localparam int unsigned SCORE_W    = 12;
    localparam int unsigned COMBO_W    = 2;

    // Ghost-eat value for a given combo step: 200, 400, 800, 1600.
    function automatic logic [SCORE_W-1:0] combo_score(input logic [COMBO_W-1:0] combo);
        return SCORE_W'(SCORE_BASE << combo);
    endfunction

endpackage

// File: rtl/frightened_flash.sv
// End-of-window flash generator: phase counter plus the white toggle register.
module frightened_flash #(
    parameter int unsigned FLASH_CYCLES = 25_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic advance_i,
    input  logic clear_i,
    output logic white_o
);

    localparam int unsigned PH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FLASH_CYCLES - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            white_q, white_d;

    // Start opens the flash white; clear forces it off; advance steps the half-period.
    always_comb begin
        phase_d = phase_q;
        white_d = white_q;
        if (start_i) begin
            phase_d = '0;
            white_d = 1'b1;
        end else if (clear_i) begin
            phase_d = '0;
            white_d = 1'b0;
        end else if (advance_i) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                white_d = ~white_q;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= '0;
            white_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            white_q <= white_d;
        end
    end

    assign white_o = white_q;

endmodule

// File: rtl/frightened_timer.sv
// Power-pellet frightened window: timer, flash, per-ghost blue flags and eat scoring.
module frightened_timer
    import frightened_pkg::*;
#(
    parameter int unsigned NUM_GHOSTS      = 4,
    parameter int unsigned DURATION_CYCLES = 500_000_000,
    parameter int unsigned FLASH_CYCLES    = 25_000_000,
    parameter int unsigned FLASH_COUNT     = 4,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pellet_eaten_i,
    input  logic [NUM_GHOSTS-1:0] ghost_eaten_i,
    input  logic                  pause_i,
    output logic                  frightened_o,
    output logic [NUM_GHOSTS-1:0] ghost_blue_o,
    output logic                  white_o,
    output logic                  score_valid_o,
    output logic [SCORE_W-1:0]    score_pts_o
);

    localparam int unsigned FLASH_WINDOW = 2 * FLASH_COUNT * FLASH_CYCLES;
    localparam bit          DIRECT_FLASH = (FLASH_WINDOW == DURATION_CYCLES);
    localparam int unsigned RUN_LAST     = DIRECT_FLASH ? 0 : DURATION_CYCLES - FLASH_WINDOW - 1;
    localparam logic [CNT_W-1:0] RUN_LAST_C = CNT_W'(RUN_LAST);
    localparam logic [CNT_W-1:0] DUR_LAST_C = CNT_W'(DURATION_CYCLES - 1);

    fright_state_t         state_q, state_d;
    logic [CNT_W-1:0]      counter_q, counter_d;
    logic [NUM_GHOSTS-1:0] ghost_blue_q, ghost_blue_d;
    logic [COMBO_W-1:0]    combo_q, combo_d;
    logic                  frightened_q;
    logic                  score_valid_q, score_valid_d;
    logic [SCORE_W-1:0]    score_pts_q, score_pts_d;

    logic                  flash_start, flash_clear, flash_adv;
    logic [NUM_GHOSTS-1:0] blue_now, eat_sel;
    logic [COMBO_W-1:0]    combo_now;

    // Keep only the lowest-index requesting ghost; the others get re-pulsed later.
    function automatic logic [NUM_GHOSTS-1:0] lowest_set(input logic [NUM_GHOSTS-1:0] req);
        logic [NUM_GHOSTS-1:0] grant;
        grant = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (req[i] && (grant == '0)) grant[i] = 1'b1;
        end
        return grant;
    endfunction

    // A same-cycle pellet restarts first, so the eat sees all ghosts blue and combo 0.
    assign blue_now  = pellet_eaten_i ? '1 : ghost_blue_q;
    assign combo_now = pellet_eaten_i ? '0 : combo_q;
    assign eat_sel   = lowest_set(ghost_eaten_i & blue_now);

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        ghost_blue_d  = blue_now & ~eat_sel;
        combo_d       = combo_now;
        score_valid_d = 1'b0;
        score_pts_d   = score_pts_q;
        flash_start   = 1'b0;
        flash_clear   = 1'b0;
        flash_adv     = 1'b0;

        if (|eat_sel) begin
            score_valid_d = 1'b1;
            score_pts_d   = combo_score(combo_now);
            combo_d       = (combo_now == COMBO_W'(COMBO_MAX)) ? combo_now : combo_now + COMBO_W'(1);
        end

        if (pellet_eaten_i) begin
            state_d     = DIRECT_FLASH ? FLASHING : RUNNING;
            counter_d   = '0;
            flash_start = DIRECT_FLASH;
            flash_clear = !DIRECT_FLASH;
        end else if (!pause_i) begin
            case (state_q)
                RUNNING: begin
                    counter_d = counter_q + CNT_W'(1);
                    if (counter_q == RUN_LAST_C) begin
                        state_d     = FLASHING;
                        flash_start = 1'b1;
                    end
                end
                FLASHING: begin
                    if (counter_q == DUR_LAST_C) begin
                        state_d      = IDLE;
                        counter_d    = '0;
                        ghost_blue_d = '0;
                        combo_d      = '0;
                        flash_clear  = 1'b1;
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                        flash_adv = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            ghost_blue_q  <= '0;
            combo_q       <= '0;
            frightened_q  <= 1'b0;
            score_valid_q <= 1'b0;
            score_pts_q   <= '0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            ghost_blue_q  <= ghost_blue_d;
            combo_q       <= combo_d;
            frightened_q  <= (state_d != IDLE);
            score_valid_q <= score_valid_d;
            score_pts_q   <= score_pts_d;
        end
    end

    frightened_flash #(
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_flash (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (flash_start),
        .advance_i(flash_adv),
        .clear_i  (flash_clear),
        .white_o  (white_o)
    );

    assign frightened_o  = frightened_q;
    assign ghost_blue_o  = ghost_blue_q;
    assign score_valid_o = score_valid_q;
    assign score_pts_o   = score_pts_q;

endmodule

// File: tb/tb_frightened_timer.sv
// Self-checking bench for frightened_timer against an elapsed-time reference model.
module tb_frightened_timer;
    import frightened_pkg::*;

    localparam int NG  = 4;
    localparam int DUR = 20;
    localparam int FC  = 2;
    localparam int FN  = 2;
    localparam int FW  = 2 * FN * FC;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pellet = 1'b0;
    logic          pause = 1'b0;
    logic [NG-1:0] ghost = '0;
    logic          fr, white, sv;
    logic [NG-1:0] blue;
    logic [11:0]   pts;

    int checks = 0;
    int errors = 0;

    // Reference model state: elapsed un-paused cycles of the current window.
    bit          m_active = 1'b0;
    int          m_el = 0;
    logic [NG-1:0] m_blue = '0;
    int          m_combo = 0;
    bit          m_sv = 1'b0;
    int          m_pts = 0;
    bit          m_white = 1'b0;

    logic [18:0] obs, expv;
    assign obs  = {fr, blue, white, sv, pts};
    assign expv = {m_active, m_blue, m_white, m_sv, 12'(m_pts)};

    always #5 clk = ~clk;

    frightened_timer #(
        .NUM_GHOSTS(NG), .DURATION_CYCLES(DUR), .FLASH_CYCLES(FC),
        .FLASH_COUNT(FN), .CNT_W(8)
    ) u_dut (
        .clk_i(clk), .reset_i(reset), .pellet_eaten_i(pellet), .ghost_eaten_i(ghost),
        .pause_i(pause), .frightened_o(fr), .ghost_blue_o(blue), .white_o(white),
        .score_valid_o(sv), .score_pts_o(pts)
    );

    task automatic step(input bit rst, input bit pel, input logic [NG-1:0] gh, input bit pz);
        logic [NG-1:0] bn;
        int cn;
        bit found;
        reset = rst; pellet = pel; ghost = gh; pause = pz;
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_el = 0; m_blue = '0; m_combo = 0; m_sv = 0; m_pts = 0;
        end else begin
            bn = pel ? '1 : m_blue;
            cn = pel ? 0 : m_combo;
            m_sv = 0;
            found = 0;
            for (int i = 0; i < NG; i++) begin
                if (!found && gh[i] && bn[i]) begin
                    found = 1; bn[i] = 1'b0; m_sv = 1;
                    m_pts = 200 * (1 << cn);
                    cn = (cn < 3) ? cn + 1 : 3;
                end
            end
            if (pel) begin
                m_active = 1; m_el = 0;
            end else if (m_active && !pz) begin
                m_el++;
                if (m_el == DUR) begin
                    m_active = 0; m_el = 0; bn = '0; cn = 0;
                end
            end
            m_blue = bn;
            m_combo = cn;
        end
        m_white = m_active && (m_el >= DUR - FW) && (((m_el - (DUR - FW)) / FC) % 2 == 0);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, '0, 0);
        step(1, 1, '1, 0);
        checks++;
        if (obs !== 19'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs, 19'd0);
        end
        checks++;
        if (obs !== expv) begin
            errors++; $display("FAIL reset_model got %h exp %h", obs, expv);
        end
    endtask

    task automatic test_window();
        int fcount = 0;
        bit ew;
        step(1, 0, '0, 0);
        for (int k = 1; k <= 22; k++) begin
            step(0, (k == 1), '0, 0);
            ew = (k == 13) || (k == 14) || (k == 17) || (k == 18);
            if (fr) fcount++;
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL window_model k=%0d got %h exp %h", k, obs, expv);
            end
            checks++;
            if (white !== ew) begin
                errors++; $display("FAIL window_white k=%0d got %b exp %b", k, white, ew);
            end
            checks++;
            if (fr !== (k <= 20) || (k <= 20 && blue !== 4'hF)) begin
                errors++; $display("FAIL window_fright k=%0d got %b/%h", k, fr, blue);
            end
            if (k == 21) begin
                checks++;
                if (obs !== 19'd0) begin
                    errors++; $display("FAIL window_expiry got %h exp 0", obs);
                end
            end
        end
        checks++;
        if (fcount != 20) begin
            errors++; $display("FAIL window_length got %0d exp 20", fcount);
        end
    endtask

    task automatic test_combo();
        int order[4]   = '{2, 0, 3, 1};
        int exp_pts[4] = '{200, 400, 800, 1600};
        int fcount = 0;
        step(1, 0, '0, 0);
        step(0, 1, '0, 0); fcount++;
        step(0, 0, '0, 0); fcount++;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, NG'(1 << order[i]), 0); fcount++;
            checks++;
            if (sv !== 1'b1 || pts !== 12'(exp_pts[i])) begin
                errors++; $display("FAIL combo_score i=%0d got %b/%0d exp 1/%0d", i, sv, pts, exp_pts[i]);
            end
            step(0, 0, '0, 0); fcount++;
            checks++;
            if (sv !== 1'b0 || pts !== 12'(exp_pts[i])) begin
                errors++; $display("FAIL combo_pulse i=%0d got %b/%0d exp 0/%0d", i, sv, pts, exp_pts[i]);
            end
        end
        checks++;
        if (blue !== 4'h0 || fr !== 1'b1) begin
            errors++; $display("FAIL combo_all_eaten got %h/%b exp 0/1", blue, fr);
        end
        for (int k = 0; k < 14; k++) begin
            step(0, 0, '0, 0);
            if (fr) fcount++;
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL combo_model k=%0d got %h exp %h", k, obs, expv);
            end
        end
        checks++;
        if (fcount != 20) begin
            errors++; $display("FAIL combo_length got %0d exp 20", fcount);
        end
    endtask

    task automatic test_restart();
        int fcount = 0;
        step(1, 0, '0, 0);
        step(0, 1, '0, 0);
        for (int k = 0; k < 15; k++) step(0, 0, 4'b0001, 0);
        step(0, 1, '0, 0); fcount++;
        checks++;
        if (white !== 1'b0 || blue !== 4'hF || fr !== 1'b1) begin
            errors++; $display("FAIL restart_state got w=%b b=%h f=%b exp 0/f/1", white, blue, fr);
        end
        step(0, 0, 4'b0001, 0); fcount++;
        checks++;
        if (sv !== 1'b1 || pts !== 12'd200) begin
            errors++; $display("FAIL restart_score got %b/%0d exp 1/200", sv, pts);
        end
        for (int k = 0; k < 24; k++) begin
            step(0, 0, '0, 0);
            if (fr) fcount++;
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL restart_model k=%0d got %h exp %h", k, obs, expv);
            end
        end
        checks++;
        if (fcount != 20) begin
            errors++; $display("FAIL restart_length got %0d exp 20", fcount);
        end
    endtask

    task automatic test_multi_eat();
        step(1, 0, '0, 0);
        step(0, 1, '0, 0);
        step(0, 0, 4'b1010, 0);
        checks++;
        if (sv !== 1'b1 || pts !== 12'd200 || blue !== 4'b1101) begin
            errors++; $display("FAIL multi_first got %b/%0d/%b exp 1/200/1101", sv, pts, blue);
        end
        step(0, 0, 4'b1000, 0);
        checks++;
        if (sv !== 1'b1 || pts !== 12'd400 || blue !== 4'b0101) begin
            errors++; $display("FAIL multi_repulse got %b/%0d/%b exp 1/400/0101", sv, pts, blue);
        end
        for (int k = 0; k < 25; k++) step(0, 0, '0, 0);
        step(0, 0, 4'hF, 0);
        checks++;
        if (sv !== 1'b0 || fr !== 1'b0) begin
            errors++; $display("FAIL idle_eat got sv=%b fr=%b exp 0/0", sv, fr);
        end
    endtask

    task automatic test_pause();
        int fcount = 0;
        logic w;
        step(1, 0, '0, 0);
        step(0, 1, '0, 0); fcount++;
        for (int k = 0; k < 13; k++) begin
            step(0, 0, '0, 0); fcount++;
        end
        w = white;
        for (int k = 0; k < 7; k++) begin
            step(0, 0, '0, 1); fcount++;
            checks++;
            if (white !== w || fr !== 1'b1 || obs !== expv) begin
                errors++; $display("FAIL pause_hold k=%0d got %h exp %h", k, obs, expv);
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(0, 0, '0, 0);
            if (fr) fcount++;
        end
        checks++;
        if (fcount != 27) begin
            errors++; $display("FAIL pause_length got %0d exp 27", fcount);
        end
    endtask

    task automatic test_reset_priority();
        step(1, 0, '0, 0);
        step(0, 1, '0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, '0, 0);
        step(1, 1, 4'hF, 0);
        checks++;
        if (obs !== 19'd0 || u_dut.state_q !== IDLE) begin
            errors++; $display("FAIL reset_priority got %h st=%0d exp 0/IDLE", obs, u_dut.state_q);
        end
    endtask

    task automatic test_random();
        bit rst, pel, pz;
        logic [NG-1:0] gh;
        step(1, 0, '0, 0);
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            pel = ($urandom_range(0, 29) == 0);
            pz  = ($urandom_range(0, 7) == 0);
            gh  = ($urandom_range(0, 3) == 0) ? NG'($urandom) : '0;
            step(rst, pel, gh, pz);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL random k=%0d got %h exp %h", k, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_combo();
        test_restart();
        test_multi_eat();
        test_pause();
        test_reset_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
